// File: rtl/serial_arith_pkg.sv
// Shared constants for the bit-serial arithmetic units: FSM state encoding
// and the default operand width.
package serial_arith_pkg;

    localparam int unsigned SERIAL_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: diff = a - b - bor_in, with the borrow out.
module full_subtractor (
    input  logic a_in,
    input  logic b_in,
    input  logic bor_in,
    output logic diff_out,
    output logic bor_out
);

    always_comb begin
        diff_out = a_in ^ b_in ^ bor_in;
        bor_out  = (~a_in & b_in) | (~(a_in ^ b_in) & bor_in);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, start/done handshake.
// Define SERIAL_SUB_SIGNED_OVF_EN to add the registered signed-overflow output.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] diff_out,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    output logic             overflow_out,
`endif
    output logic             borrow_out
);

    localparam int unsigned          CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bor_q, bor_d;
    logic               borrow_q, borrow_d;
    logic               fs_diff, fs_bor;
    logic               load;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    full_subtractor u_fs (
        .a_in     (a_sr_q[0]),
        .b_in     (b_sr_q[0]),
        .bor_in   (bor_q),
        .diff_out (fs_diff),
        .bor_out  (fs_bor)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        bor_d    = bor_q;
        borrow_d = borrow_q;
        load     = 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_in) load = 1'b1;
            end
            ST_SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                res_d  = {fs_diff, res_q[WIDTH-1:1]};
                bor_d  = fs_bor;
                cnt_d  = cnt_q + 1'b1;
                // Output registers see the final bit directly, not via res_q.
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    diff_d   = {fs_diff, res_q[WIDTH-1:1]};
                    borrow_d = fs_bor;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    ovf_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ fs_diff);
`endif
                end
            end
            ST_DONE: begin
                if (start_in) load = 1'b1;
                else          state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            state_d = ST_SHIFT;
            a_sr_d  = a_in;
            b_sr_d  = b_in;
            bor_d   = 1'b0;
            cnt_d   = '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_d = a_in[WIDTH-1];
            b_msb_d = b_in[WIDTH-1];
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bor_q    <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            bor_q    <= bor_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy_out   = (state_q == ST_SHIFT);
    assign done_out   = (state_q == ST_DONE);
    assign diff_out   = diff_q;
    assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    assign overflow_out = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, borrow;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic         ovf;
`endif

    int unsigned  n_tests = 0;
    int unsigned  n_fail  = 0;
    logic [W-1:0] hold_diff = '0;
    logic         hold_bor  = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .start_in   (start),
        .a_in       (a),
        .b_in       (b),
        .busy_out   (busy),
        .done_out   (done),
        .diff_out   (diff),
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        .overflow_out (ovf),
`endif
        .borrow_out (borrow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full operation: accept, WIDTH busy cycles with held outputs, then done.
    task automatic run_op(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic [W-1:0] exp_d, input logic exp_b, input logic exp_ovf);
        start = 1'b1; a = aa; b = bb;
        tick();
        start = 1'b0; a = ~aa; b = ~bb;
        for (int i = 0; i < W; i++) begin
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_nodone"}, done, 1'b0);
            check({tag, "_hold"}, diff, hold_diff);
            tick();
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_lo"}, busy, 1'b0);
        check({tag, "_diff"}, diff, exp_d);
        check({tag, "_borrow"}, borrow, exp_b);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        check({tag, "_ovf"}, ovf, exp_ovf);
`else
        if (exp_ovf === 1'bx) $display("unused");
`endif
        hold_diff = exp_d;
        hold_bor  = exp_b;
        tick();
        check({tag, "_idle"}, done, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_diff", diff, 8'h00);
        check("rst_borrow", borrow, 1'b0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 1'b0);

        run_op("t1", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op("t2a", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op("t2b", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        run_op("t2c", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

        // Back-to-back with start held; new operands presented in the DONE cycle.
        start = 1'b1; a = 8'h10; b = 8'h01;
        tick();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < W; i++) begin
                check("t3_busy", busy, 1'b1);
                check("t3_hold", diff, hold_diff);
                tick();
            end
            check("t3_done", done, 1'b1);
            check("t3_diff", diff, (r < 2) ? 8'h0F : 8'h1D);
            check("t3_borrow", borrow, 1'b0);
            hold_diff = (r < 2) ? 8'h0F : 8'h1D;
            if (r == 1) begin a = 8'h20; b = 8'h03; end
            if (r == 2) start = 1'b0;
            tick();
        end
        check("t3_idle_busy", busy, 1'b0);
        check("t3_idle_done", done, 1'b0);

        // Start re-pulsed mid-operation is ignored.
        start = 1'b1; a = 8'hAA; b = 8'h55;
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i == 3) begin start = 1'b1; a = 8'h00; b = 8'h01; end
            else start = 1'b0;
            check("t4_busy", busy, 1'b1);
            check("t4_nodone", done, 1'b0);
            tick();
        end
        start = 1'b0;
        check("t4_done", done, 1'b1);
        check("t4_diff", diff, 8'h55);
        check("t4_borrow", borrow, 1'b0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        check("t4_ovf", ovf, 1'b1);
`endif
        hold_diff = 8'h55;
        tick();
        check("t4_idle", busy, 1'b0);

        // Reset in the middle of an operation.
        start = 1'b1; a = 8'h05; b = 8'h03;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t5_busy_pre", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        check("t5_diff", diff, 8'h00);
        check("t5_borrow", borrow, 1'b0);
        hold_diff = '0;
        for (int i = 0; i < 12; i++) begin
            check("t5_nodone", done, 1'b0);
            tick();
        end

        // Reset and start on the same edge: reset wins.
        rst = 1'b1; start = 1'b1; a = 8'h09; b = 8'h01;
        tick();
        rst = 1'b0; start = 1'b0;
        check("t5_rst_start", busy, 1'b0);
        tick();
        check("t5_rst_start2", busy, 1'b0);

        run_op("t5_after", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op("t6a", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op("t6b", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op("t6c", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock, through a single full-subtractor cell.
- Arithmetic counterpart to the team's combinational half-adder: the subtract direction, implemented sequentially.
- Used as a low-area arithmetic unit in the lab datapath, driven by a start/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk_in  input  1  single clock, rising-edge.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  request; sampled on a rising edge in IDLE or DONE.
- a_in  input  WIDTH  minuend; captured when start is accepted.
- b_in  input  WIDTH  subtrahend; captured when start is accepted.
- busy_out  output  1  high while bits are being processed.
- done_out  output  1  one-cycle pulse when the result is valid.
- diff_out  output  WIDTH  a - b modulo 2^WIDTH.
- borrow_out  output  1  final borrow; 1 when a < b unsigned.

Behaviour:
- Interface: one clock (clk_in); reset rst_in is synchronous, active-high.
- Reset values: state=IDLE, busy_out=0, done_out=0, diff_out=0, borrow_out=0, internal shift registers=0, bit counter=0, borrow flop=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on start_in=1.
  - Load a_sr<=a_in, b_sr<=b_in, bor<=0, cnt<=0.
- SHIFT, each cycle:
  - d = a_sr[0]^b_sr[0]^bor.
  - bor_n = (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&bor).
  - Shift a_sr and b_sr right by one.
  - Shift d into the result register at the MSB (shift right).
  - bor<=bor_n; cnt<=cnt+1.
- SHIFT -> DONE on the edge that processes bit WIDTH-1 (cnt==WIDTH-1).
  - diff_out and borrow_out update on that same edge.
- DONE: done_out=1 for exactly this cycle.
  - If start_in=1: go to SHIFT with new operands (back-to-back operation).
  - Otherwise: go to IDLE.
- Latency: start accepted at edge k -> busy_out=1 during cycles k+1..k+WIDTH -> done_out=1 in the cycle after edge k+WIDTH. Total WIDTH+1 cycles from start to done.
- busy_out = (state==SHIFT). done_out = (state==DONE). Both are registered state decodes.
- diff_out/borrow_out hold their last result until the next completion. They do not change during SHIFT; results accumulate in an internal register and are copied out at completion.
- start_in while in SHIFT: ignored; no restart and no queuing.
- a_in/b_in changes after capture: no effect on the operation in flight.
- Reset mid-operation: the next edge forces all reset values; the partial result is discarded and no done pulse is produced.
- Reset and start asserted on the same edge: reset wins.
- Counter width is $clog2(WIDTH). No other wrap-around is possible, since cnt is cleared on every start.

Optional Feature:
- Macro: SERIAL_SUB_SIGNED_OVF_EN.
- Defined:
  - Adds port overflow_out, output, 1 bit.
  - Registered at completion as (a_msb ^ b_msb) & (a_msb ^ diff_msb), using the captured operand MSBs. This is two's-complement signed overflow.
  - Reset value 0; held like diff_out.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_arith_pkg holds:
  - FSM state encoding constants: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - The default WIDTH constant.
- Sub-module full_subtractor is purely combinational.
  - Inputs: a_in, b_in, bor_in.
  - Outputs: diff_out, bor_out.
  - Instantiated once in the serial loop.
- Top module: FSM, counter, shift registers, output registers.

Test Plan:
1. WIDTH=8, a=0x05, b=0x03, start for 1 cycle -> busy_out high 8 cycles, done_out pulse at cycle 9, diff_out=0x02, borrow_out=0.
2. a=0x03, b=0x05 -> diff_out=0xFE, borrow_out=1. Then a=0x00, b=0x01 -> diff_out=0xFF, borrow_out=1. Then a=0xFF, b=0xFF -> diff_out=0x00, borrow_out=0.
3. start held high continuously with a=0x10, b=0x01 -> done_out pulses every 9 cycles, diff_out=0x0F each time. A different operand pair applied at the DONE cycle is captured and its result appears 9 cycles later.
4. start pulsed again at SHIFT cycle 3, with a=0xAA, b=0x55 loaded initially -> ignored; result is diff_out=0x55 on schedule.
5. rst_in asserted at SHIFT cycle 4 -> next edge busy_out=0, done_out=0, diff_out=0, borrow_out=0; no done pulse follows. A new start then completes normally.
6. With SERIAL_SUB_SIGNED_OVF_EN: a=0x80, b=0x01 -> diff_out=0x7F, overflow_out=1. a=0x05, b=0x03 -> overflow_out=0.
